// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial decoupler:
//   - width helpers that derive the lane-index field and the beat-serial field
//     of a tag from the tag width and the lane count;
//   - tag pack/unpack helpers. A tag is {beat_serial, lane_index}, with the
//     lane index in the low TUPLE_BITS bits.
//   Tag helpers operate on a 32-bit working word. Callers size-cast the
//   result down to their own tag width.
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam int TAG_MAX_W = 32;

  typedef logic [TAG_MAX_W-1:0] tag_word_t;

  // Number of tag bits that identify the lane within a beat.
  function automatic int tuple_bits(input int num_elements);
    return $clog2(num_elements);
  endfunction

  // Number of tag bits left over for the per-beat serial number.
  function automatic int serial_beat_bits(input int serial_width, input int num_elements);
    return serial_width - tuple_bits(num_elements);
  endfunction

  // {serial, lane} packed into one word.
  function automatic tag_word_t pack_tag(input tag_word_t serial, input tag_word_t lane,
                                         input int tuple_w);
    return (serial << tuple_w) | lane;
  endfunction

  // Beat serial recovered from a tag.
  function automatic tag_word_t tag_serial(input tag_word_t tag, input int tuple_w);
    return tag >> tuple_w;
  endfunction

  // Lane index recovered from a tag.
  function automatic tag_word_t tag_lane(input tag_word_t tag, input int tuple_w);
    return tag & ((tag_word_t'(1) << tuple_w) - tag_word_t'(1));
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// -----------------------------------------------------------------------------
// lane_fifo
//   First-word-fall-through FIFO for a single output lane. The head entry is
//   always presented on out_entry, and out_valid is derived from the registered
//   occupancy. An entry pushed at edge N is therefore visible right after N.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     flush        synchronous clear of occupancy and pointers
//     push         write push_entry (ignored while full or flushing)
//     push_entry   entry to enqueue
//     out_valid    head entry present
//     out_ready    consumer accepts the head entry
//     out_entry    head entry, held stable until popped
//     count        registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module lane_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_entry,
  output logic             out_valid,
  input  logic             out_ready,
  output entry_t           out_entry,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic full;
  logic push_ok;
  logic pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_entry = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign pop     = out_valid && out_ready;
  assign push_ok = push && !full;

  // NOTE: every signal written here gets its default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      // DEPTH is a power of two, so the pointer wraps by plain overflow.
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so that
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset. Occupancy and pointers decide what
  // is valid, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/serial_decoupler_buffered.sv
// -----------------------------------------------------------------------------
// serial_decoupler_buffered
//   Splits each accepted beat of an NUM_ELEMENTS-wide stream into one entry per
//   lane. Each entry is tagged {beat_serial, lane_index} so that a downstream
//   reorder stage can restore the original order. Every lane has its own
//   LANE_DEPTH FIFO, so lanes drain independently. The input stalls only while
//   some lane is full.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     flush         synchronous clear of all lane FIFOs (serial kept)
//     in_valid      input beat present
//     in_ready      beat can be taken (registered occupancy and flush only)
//     in_data       NUM_ELEMENTS x DATA_WIDTH, lane I at [I*DATA_WIDTH +: DATA_WIDTH]
//     in_keep       per-lane keep flag
//     in_last       end-of-packet marker for the beat
//     out_valid     per-lane head present
//     out_ready     per-lane consumer ready
//     out_data      per-lane data, same packing as in_data
//     out_tag       per-lane tag, lane I at [I*SERIAL_WIDTH +: SERIAL_WIDTH]
//     out_keep      per-lane keep
//     out_last      per-lane last
//     fill_level    per-lane occupancy, lane I at [I*CNT_W +: CNT_W]
//     serial_o      serial number the next accepted beat will carry
// -----------------------------------------------------------------------------
module serial_decoupler_buffered
  import serial_pkg::*;
#(
  parameter int  DATA_WIDTH       = 32,
  parameter int  NUM_ELEMENTS     = 4,
  parameter int  SERIAL_WIDTH     = 16,
  parameter int  LANE_DEPTH       = 4,
  parameter bit  SKIP_EMPTY       = 1'b0,
  localparam int TUPLE_BITS       = tuple_bits(NUM_ELEMENTS),
  localparam int SERIAL_BEAT_BITS = serial_beat_bits(SERIAL_WIDTH, NUM_ELEMENTS),
  localparam int CNT_W            = $clog2(LANE_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_ELEMENTS-1:0]              in_keep,
  input  logic                                 in_last,
  output logic [NUM_ELEMENTS-1:0]              out_valid,
  input  logic [NUM_ELEMENTS-1:0]              out_ready,
  output logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_ELEMENTS*SERIAL_WIDTH-1:0] out_tag,
  output logic [NUM_ELEMENTS-1:0]              out_keep,
  output logic [NUM_ELEMENTS-1:0]              out_last,
  output logic [NUM_ELEMENTS*CNT_W-1:0]        fill_level,
  output logic [SERIAL_BEAT_BITS-1:0]          serial_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NUM_ELEMENTS < 2) begin : g_bad_num_elements
    $error("serial_decoupler_buffered: NUM_ELEMENTS must be >= 2");
  end
  if (SERIAL_WIDTH <= TUPLE_BITS) begin : g_bad_serial_width
    $error("serial_decoupler_buffered: SERIAL_WIDTH must exceed the lane-index bits");
  end
  if (SERIAL_WIDTH > TAG_MAX_W) begin : g_bad_tag_width
    $error("serial_decoupler_buffered: SERIAL_WIDTH exceeds the tag working width");
  end
  if ((LANE_DEPTH < 2) || ((LANE_DEPTH & (LANE_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("serial_decoupler_buffered: LANE_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [SERIAL_WIDTH-1:0] tag;
    logic                    keep;
    logic                    last;
  } lane_entry_t;

  // ---------------------------------------------------------------------------
  // Lane occupancy and input handshake
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        lane_count [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] lane_push;
  logic                    any_full;
  logic                    accept;

  // in_ready looks only at registered counts. A full lane that pops in this
  // cycle still stalls the input, which keeps out_ready off the in_ready path.
  always_comb begin
    any_full = 1'b0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (lane_count[i] == CNT_W'(LANE_DEPTH)) begin
        any_full = 1'b1;
      end
    end
  end

  assign in_ready = !flush && !any_full;
  assign accept   = in_valid && in_ready;

  // In sparse mode, dropped elements never reach their lane. Last beats still
  // push everywhere so every lane sees the end-of-packet marker.
  always_comb begin
    lane_push = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      lane_push[i] = accept && !(SKIP_EMPTY && !in_keep[i] && !in_last);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat serial counter: one step per accepted beat, whatever the lane mask.
  // It wraps modulo 2^SERIAL_BEAT_BITS and is not affected by flush.
  // ---------------------------------------------------------------------------
  logic [SERIAL_BEAT_BITS-1:0] serial_q, serial_d;

  always_comb begin
    serial_d = serial_q;
    if (accept) begin
      serial_d = serial_q + SERIAL_BEAT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      serial_q <= '0;
    end else begin
      serial_q <= serial_d;
    end
  end

  assign serial_o = serial_q;

  // ---------------------------------------------------------------------------
  // Per-lane FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
    lane_entry_t push_entry;
    lane_entry_t head;

    always_comb begin
      push_entry.data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      push_entry.tag  = SERIAL_WIDTH'(pack_tag(tag_word_t'(serial_q), tag_word_t'(i),
                                               TUPLE_BITS));
      push_entry.keep = in_keep[i];
      push_entry.last = in_last;
    end

    lane_fifo #(
      .entry_t (lane_entry_t),
      .DEPTH   (LANE_DEPTH)
    ) u_lane_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (lane_push[i]),
      .push_entry (push_entry),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i]),
      .out_entry  (head),
      .count      (lane_count[i])
    );

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH]     = head.data;
    assign out_tag[i*SERIAL_WIDTH +: SERIAL_WIDTH]  = head.tag;
    assign out_keep[i]                              = head.keep;
    assign out_last[i]                              = head.last;
    assign fill_level[i*CNT_W +: CNT_W]             = lane_count[i];
  end

endmodule

// File: tb/tb_serial_decoupler_buffered.sv
// -----------------------------------------------------------------------------
// tb_serial_decoupler_buffered
//   Two instances share clk/rst: instance 0 is dense (SKIP_EMPTY=0), and
//   instance 1 is sparse (SKIP_EMPTY=1). A reference model keeps one queue of
//   expected entries per lane. Every negative edge it compares the visible DUT
//   state against the queues, then applies the handshakes that the coming
//   posedge will perform. Directed sequences add explicit checks for the
//   corner cases.
// -----------------------------------------------------------------------------
module tb_serial_decoupler_buffered;

  localparam int NE    = 4;
  localparam int DW    = 32;
  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int SBB   = 14;

  logic clk = 1'b0;
  logic rst;

  logic              flush      [2];
  logic              in_valid   [2];
  logic              in_ready   [2];
  logic [NE*DW-1:0]  in_data    [2];
  logic [NE-1:0]     in_keep    [2];
  logic              in_last    [2];
  logic [NE-1:0]     out_valid  [2];
  logic [NE-1:0]     out_ready  [2];
  logic [NE*DW-1:0]  out_data   [2];
  logic [NE*SW-1:0]  out_tag    [2];
  logic [NE-1:0]     out_keep   [2];
  logic [NE-1:0]     out_last   [2];
  logic [NE*CW-1:0]  fill_level [2];
  logic [SBB-1:0]    serial_o   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    serial_decoupler_buffered #(
      .DATA_WIDTH   (DW),
      .NUM_ELEMENTS (NE),
      .SERIAL_WIDTH (SW),
      .LANE_DEPTH   (DEPTH),
      .SKIP_EMPTY   (g == 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .in_keep    (in_keep[g]),
      .in_last    (in_last[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .out_tag    (out_tag[g]),
      .out_keep   (out_keep[g]),
      .out_last   (out_last[g]),
      .fill_level (fill_level[g]),
      .serial_o   (serial_o[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int idx,
                       input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, idx, $time, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of expected entries per lane per instance
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] tag;
    logic          keep;
    logic          last;
  } exp_t;

  exp_t        mq [2][NE][$];
  int unsigned mserial [2];
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mon_en) begin
        bit room;
        room = 1'b1;
        for (int l = 0; l < NE; l++) begin
          if (mq[g][l].size() >= DEPTH) room = 1'b0;
        end
        check("in_ready", g, 64'(in_ready[g]), 64'(!flush[g] && room));
        check("serial_o", g, 64'(serial_o[g]), 64'(mserial[g]));
        for (int l = 0; l < NE; l++) begin
          check("fill_level", g*NE+l, 64'(fill_level[g][l*CW +: CW]), 64'(mq[g][l].size()));
          check("out_valid", g*NE+l, 64'(out_valid[g][l]), 64'(mq[g][l].size() != 0));
          if (out_valid[g][l] && mq[g][l].size() != 0) begin
            check("out_data", g*NE+l, 64'(out_data[g][l*DW +: DW]), 64'(mq[g][l][0].data));
            check("out_tag",  g*NE+l, 64'(out_tag[g][l*SW +: SW]),  64'(mq[g][l][0].tag));
            check("out_keep", g*NE+l, 64'(out_keep[g][l]),          64'(mq[g][l][0].keep));
            check("out_last", g*NE+l, 64'(out_last[g][l]),          64'(mq[g][l][0].last));
          end
        end
      end

      // Apply what the next posedge does.
      if (rst) begin
        for (int l = 0; l < NE; l++) mq[g][l].delete();
        mserial[g] = 0;
      end else if (flush[g]) begin
        for (int l = 0; l < NE; l++) mq[g][l].delete();
      end else begin
        for (int l = 0; l < NE; l++) begin
          if (out_valid[g][l] && out_ready[g][l] && mq[g][l].size() != 0)
            void'(mq[g][l].pop_front());
        end
        if (in_valid[g] && in_ready[g]) begin
          for (int l = 0; l < NE; l++) begin
            if (!(g == 1 && !in_keep[g][l] && !in_last[g])) begin
              exp_t e;
              e.data = in_data[g][l*DW +: DW];
              e.tag  = SW'(mserial[g] * NE + l);
              e.keep = in_keep[g][l];
              e.last = in_last[g];
              mq[g][l].push_back(e);
            end
          end
          mserial[g] = (mserial[g] + 1) % (1 << SBB);
        end
      end
    end
    if (rst) mon_en = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int g, input logic v, input logic [NE-1:0] keep,
                            input logic last);
    in_valid[g] = v;
    in_keep[g]  = keep;
    in_last[g]  = last;
    for (int l = 0; l < NE; l++) in_data[g][l*DW +: DW] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      flush[g]     = 1'b0;
      out_ready[g] = '1;
    end
    repeat (n) cyc();
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequences
  // ---------------------------------------------------------------------------
  initial begin
    int          acc;
    int          cycles;
    bit          was_ready;
    logic [SBB-1:0] saved_serial;

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      flush[g]     = 1'b0;
      in_last[g]   = 1'b0;
      in_keep[g]   = '0;
      in_data[g]   = '0;
      in_valid[g]  = 1'b0;
      out_ready[g] = '1;
    end
    repeat (2) cyc();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) check("reset_serial", g, 64'(serial_o[g]), 64'(0));

    // Three beats. Lane 2 shows tags 0x2, 0x6, 0xA one cycle after each accept.
    for (int k = 0; k < 3; k++) begin
      drive_beat(0, 1'b1, 4'hF, k == 2);
      cyc();
      check("t1_valid_l2", k, 64'(out_valid[0][2]), 64'(1));
      check("t1_tag_l2", k, 64'(out_tag[0][2*SW +: SW]), 64'(4*k + 2));
    end
    idle(3);

    // Lane 1 stalled: exactly DEPTH beats get in, then the input stalls.
    out_ready[0] = 4'b1101;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      drive_beat(0, 1'b1, 4'hF, 1'b0);
      was_ready = in_ready[0];
      cyc();
      if (was_ready) acc++;
    end
    check("stall_accepts", 0, 64'(acc), 64'(DEPTH));
    check("stall_in_ready", 0, 64'(in_ready[0]), 64'(0));
    check("stall_fill_l1", 0, 64'(fill_level[0][1*CW +: CW]), 64'(DEPTH));
    for (int l = 0; l < NE; l++)
      if (l != 1) check("stall_fill_other", l, 64'(fill_level[0][l*CW +: CW]), 64'(0));
    out_ready[0] = 4'b1111;
    cyc();
    check("unstall_in_ready", 0, 64'(in_ready[0]), 64'(1));
    idle(8);

    // Flush with two entries per lane. The serial number carries over.
    out_ready[0] = '0;
    for (int c = 0; c < 2; c++) begin
      drive_beat(0, 1'b1, 4'hF, 1'b0);
      cyc();
    end
    in_valid[0] = 1'b0;
    for (int l = 0; l < NE; l++) check("preflush_fill", l, 64'(fill_level[0][l*CW +: CW]), 64'(2));
    saved_serial = serial_o[0];
    flush[0] = 1'b1;
    drive_beat(0, 1'b1, 4'hF, 1'b0);
    #1;
    check("flush_in_ready", 0, 64'(in_ready[0]), 64'(0));
    cyc();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    for (int l = 0; l < NE; l++) begin
      check("postflush_valid", l, 64'(out_valid[0][l]), 64'(0));
      check("postflush_fill", l, 64'(fill_level[0][l*CW +: CW]), 64'(0));
    end
    check("postflush_serial", 0, 64'(serial_o[0]), 64'(saved_serial));
    out_ready[0] = '1;
    drive_beat(0, 1'b1, 4'hF, 1'b0);
    cyc();
    in_valid[0] = 1'b0;
    check("postflush_tag_l0", 0, 64'(out_tag[0][0 +: SW]), 64'({saved_serial, 2'b00}));
    idle(3);

    // Sparse mode: lanes 1 and 3 only see the last beat.
    drive_beat(1, 1'b1, 4'b0101, 1'b0);
    cyc();
    check("skip_b0_valid", 1, 64'(out_valid[1]), 64'(4'b0101));
    drive_beat(1, 1'b1, 4'b0001, 1'b1);
    cyc();
    in_valid[1] = 1'b0;
    check("skip_b1_valid", 1, 64'(out_valid[1]), 64'(4'b1111));
    check("skip_tag_l1", 1, 64'(out_tag[1][1*SW +: SW]), 64'(16'h0005));
    check("skip_keep_l1", 1, 64'(out_keep[1][1]), 64'(0));
    check("skip_last_l1", 1, 64'(out_last[1][1]), 64'(1));
    check("skip_tag_l3", 3, 64'(out_tag[1][3*SW +: SW]), 64'(16'h0007));
    check("skip_tag_l0", 0, 64'(out_tag[1][0 +: SW]), 64'(16'h0004));
    idle(3);

    // Random traffic on both instances, with random back-pressure and flush.
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 2; g++) begin
        drive_beat(g, ($urandom % 4) != 0, 4'($urandom), ($urandom % 4) == 0);
        out_ready[g] = 4'($urandom) | 4'($urandom);
        flush[g]     = ($urandom % 64) == 0;
      end
      cyc();
    end
    idle(10);

    // Reset mid-stream with every lane holding data.
    out_ready[0] = '0;
    for (int c = 0; c < 3; c++) begin
      drive_beat(0, 1'b1, 4'hF, 1'b0);
      cyc();
    end
    in_valid[0] = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int l = 0; l < NE; l++) begin
      check("rst_valid", l, 64'(out_valid[0][l]), 64'(0));
      check("rst_fill", l, 64'(fill_level[0][l*CW +: CW]), 64'(0));
    end
    check("rst_serial", 0, 64'(serial_o[0]), 64'(0));
    check("rst_in_ready", 0, 64'(in_ready[0]), 64'(1));
    out_ready[0] = '1;
    cyc();

    // Serial wrap: 2^14+2 beats. Beat 16384 carries serial 0, and the last
    // beat (16385) carries serial 1, so serial_o then reads 2.
    acc    = 0;
    cycles = 0;
    while (acc < (1 << SBB) + 2 && cycles < 20000) begin
      drive_beat(0, 1'b1, 4'hF, 1'b0);
      was_ready = in_ready[0];
      cyc();
      cycles++;
      if (was_ready) begin
        if (acc == (1 << SBB)) begin
          for (int l = 0; l < NE; l++)
            check("wrap_tag", l, 64'(out_tag[0][l*SW +: SW]), 64'(l));
        end
        if (acc == (1 << SBB) + 1)
          check("wrap_last_tag_l0", 0, 64'(out_tag[0][0 +: SW]), 64'(16'h0004));
        acc++;
      end
    end
    in_valid[0] = 1'b0;
    check("wrap_accepts", 0, 64'(acc), 64'((1 << SBB) + 2));
    check("wrap_serial_o", 0, 64'(serial_o[0]), 64'(2));
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
